// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: drives freeze, flush and bubble controls for the
// IF/ID, ID/EXE and EXE/MEM registers from load-use, taken-jump and cache-miss
// conditions, and keeps saturating stall/flush counters and a miss-timeout flag.
module hazard_stall_ctrl #(
    parameter int unsigned MISS_TIMEOUT = 64,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_uses_src2,
    input  logic [4:0]       ex_dest,
    input  logic             ex_reg_write,
    input  logic             ex_mem_to_reg,
    input  logic [1:0]       ex_jump,
    input  logic             mem_cache_en,
    input  logic             cache_ready,
    output logic             freeze_pc,
    output logic             freeze_ifid,
    output logic             freeze_idex,
    output logic             freeze_exmem,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned MissW = $clog2(MISS_TIMEOUT + 1);

    typedef enum logic [1:0] {StRun, StMiss, StFlush} state_e;

    state_e           state_q, state_d;
    logic [MissW-1:0] miss_cnt_q, miss_cnt_d;
    logic [1:0]       flush_left_q, flush_left_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic miss;
    logic load_use;
    logic jmp;

    assign miss     = mem_cache_en & ~cache_ready;
    assign jmp      = (ex_jump != 2'd0);
    // $0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_to_reg & ex_reg_write & (ex_dest != 5'd0) &
                      ((ex_dest == id_src1) | (id_uses_src2 & (ex_dest == id_src2)));

    // Next-state and zero-latency control outputs from state and current inputs.
    always_comb begin
        state_d      = state_q;
        miss_cnt_d   = miss_cnt_q;
        flush_left_d = flush_left_q;
        err_d        = err_q;
        freeze_pc    = 1'b0;
        freeze_ifid  = 1'b0;
        freeze_idex  = 1'b0;
        freeze_exmem = 1'b0;
        bubble_idex  = 1'b0;
        flush_ifid   = 1'b0;

        unique case (state_q)
            StRun: begin
                if (miss) begin
                    {freeze_pc, freeze_ifid, freeze_idex, freeze_exmem} = 4'b1111;
                    state_d    = StMiss;
                    miss_cnt_d = MissW'(1);
                end else if (jmp) begin
                    // ID instruction is discarded, so a concurrent load-use is moot.
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d      = StFlush;
                        flush_left_d = 2'(FLUSH_CYCLES - 1);
                    end
                end else if (load_use) begin
                    freeze_pc   = 1'b1;
                    freeze_ifid = 1'b1;
                    bubble_idex = 1'b1;
                end
            end
            StMiss: begin
                if (cache_ready) begin
                    state_d = StRun;
                end else if (miss_cnt_q == MissW'(MISS_TIMEOUT)) begin
                    // Give up on the access: release the pipe and flag the error.
                    err_d   = 1'b1;
                    state_d = StRun;
                end else begin
                    {freeze_pc, freeze_ifid, freeze_idex, freeze_exmem} = 4'b1111;
                    miss_cnt_d = miss_cnt_q + MissW'(1);
                end
            end
            StFlush: begin
                if (miss) begin
                    // Frozen fetch is re-flushed on resume, so drop the remainder.
                    {freeze_pc, freeze_ifid, freeze_idex, freeze_exmem} = 4'b1111;
                    state_d      = StMiss;
                    miss_cnt_d   = MissW'(1);
                    flush_left_d = 2'd0;
                end else begin
                    flush_ifid   = 1'b1;
                    flush_left_d = flush_left_q - 2'd1;
                    if (flush_left_q == 2'd1) begin
                        state_d = StRun;
                    end
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase

        // Controls are forced low for as long as reset is held.
        if (rst) begin
            freeze_pc    = 1'b0;
            freeze_ifid  = 1'b0;
            freeze_idex  = 1'b0;
            freeze_exmem = 1'b0;
            bubble_idex  = 1'b0;
            flush_ifid   = 1'b0;
        end
    end

    // Saturating performance counter next values.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (freeze_pc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_ifid && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State, counters and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            miss_cnt_q   <= '0;
            flush_left_q <= '0;
            err_q        <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            miss_cnt_q   <= miss_cnt_d;
            flush_left_q <= flush_left_d;
            err_q        <= err_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign err_timeout = err_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Control side of the pipeline-register freeze/bubble interface. Sits beside the ID/EXE pipeline register and drives its freeze input and bubble injection.
- Watches ID-stage source registers, EXE-stage destination/load/jump fields and the MEM-stage cache handshake.
- Produces freeze, flush and bubble controls for the IF/ID, ID/EXE and EXE/MEM registers, plus stall/flush performance counters and a miss-timeout error.
- A bubble is injected by forcing the ID/EXE instruction input to zero, which clears that register.

Parameters:
MISS_TIMEOUT, 64, max cycles in MISS before abort (≥2)
FLUSH_CYCLES, 1, cycles IF/ID is flushed after a taken jump (1..3)
CNT_W, 16, width of performance counters

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
id_src1  input  5  rs of instruction in ID
id_src2  input  5  rt of instruction in ID
id_uses_src2  input  1  ID instruction reads rt
ex_dest  input  5  dest field currently held in ID/EXE register
ex_reg_write  input  1  EXE instruction writes a register
ex_mem_to_reg  input  1  EXE instruction is a load
ex_jump  input  2  jump code in EXE; nonzero = taken control transfer
mem_cache_en  input  1  MEM-stage instruction accesses cache
cache_ready  input  1  cache completed the MEM-stage access this cycle
freeze_pc  output  1  hold PC
freeze_ifid  output  1  hold IF/ID register
freeze_idex  output  1  hold ID/EXE register (its freeze input)
freeze_exmem  output  1  hold EXE/MEM register
bubble_idex  output  1  force ID/EXE instruction input to 0
flush_ifid  output  1  clear IF/ID register
err_timeout  output  1  sticky miss-timeout flag
stall_cnt  output  CNT_W  cycles with freeze_pc=1, saturating
flush_cnt  output  CNT_W  cycles with flush_ifid=1, saturating

Behaviour:
- Reset (async, rst=1): state=RUN; all control outputs 0; err_timeout=0; stall_cnt=flush_cnt=0; internal miss/flush counters 0. Reset mid-MISS or mid-FLUSH aborts immediately to RUN.
- Control outputs are combinational from state and current inputs (zero latency). Counters and the error flag update on the clock edge.
- States: RUN, MISS, FLUSH.
- miss = mem_cache_en & ~cache_ready.
- load_use = ex_mem_to_reg & ex_reg_write & (ex_dest≠0) & ((ex_dest==id_src1) | (id_uses_src2 & ex_dest==id_src2)).
- jmp = (ex_jump≠0).
- RUN, evaluated in priority order:
  - miss: freeze_pc=freeze_ifid=freeze_idex=freeze_exmem=1; next=MISS; miss counter=1.
  - else jmp: flush_ifid=1, bubble_idex=1. If FLUSH_CYCLES>1, next=FLUSH with flush counter=FLUSH_CYCLES-1. A simultaneous load_use is ignored, because the ID instruction is discarded.
  - else load_use: freeze_pc=freeze_ifid=1, bubble_idex=1 for exactly this cycle; stay RUN. The hazard clears on the next edge as the load advances.
  - else all controls 0.
- MISS:
  - All four freezes held at 1; bubble and flush are 0; jmp and load_use are ignored.
  - cache_ready=1: freezes drop to 0 in that same cycle; next=RUN.
  - Otherwise the miss counter increments. If the counter reaches MISS_TIMEOUT, err_timeout is set (sticky until rst), freezes drop this cycle and next=RUN.
- FLUSH:
  - flush_ifid=1, bubble_idex=0; the counter decrements and next=RUN when it reaches 0.
  - If miss occurs in FLUSH, MISS takes priority. The remaining flush count is dropped, because the frozen fetch is re-flushed on resume.
- stall_cnt increments each cycle freeze_pc=1; flush_cnt increments each cycle flush_ifid=1. Both saturate at 2^CNT_W-1 with no wrap.
- ex_dest=0 never causes a load-use stall (register $0).

Test Plan:
- Load-use: ex_mem_to_reg=1, ex_reg_write=1, ex_dest=5, id_src1=5 for one cycle -> freeze_pc=freeze_ifid=bubble_idex=1 in that cycle only; stall_cnt=1.
- Load-use on rt gated: ex_dest=7, id_src2=7, id_uses_src2=0 -> no stall. Repeat with id_uses_src2=1 -> 1-cycle stall.
- Miss: mem_cache_en=1, cache_ready=0 for 5 cycles, then 1 -> all four freezes high for 5 cycles and low in the ready cycle; stall_cnt=5; err_timeout=0.
- Timeout: MISS_TIMEOUT=8, cache_ready held 0 -> freezes drop after 8 cycles; err_timeout=1 and stays 1 until rst pulse.
- Priority: jmp+load_use in the same cycle -> flush_ifid=1, bubble_idex=1, freeze_pc=0; flush_cnt=1. With FLUSH_CYCLES=3 -> flush_ifid high for 3 cycles.
- Async reset mid-MISS: assert rst between edges -> all outputs 0 immediately; the next cycle without miss shows RUN behaviour.
